// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: state encoding and counter sizing
// shared by the digit-serial adder and its cells.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: combinational 1-bit sum/carry,
// chained DIGIT-wide inside serial_adder.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder.sv
// serial_adder: {cout,s} = a + b + cin, DIGIT bits per clock.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2(N);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [DIGIT-1:0] w_sum;
  logic [DIGIT:0]   w_c;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  assign w_c[0] = r_carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder_cell u_fa (
      .i_a (r_a[i]),
      .i_b (r_b[i]),
      .i_c (w_c[i]),
      .o_s (w_sum[i]),
      .o_c (w_c[i+1])
    );
  end

  // The A register doubles as the result shift register:
  // sum digits enter at the top as operand digits leave the bottom.
  if (DIGIT < WIDTH) begin : g_shift
    assign w_a_nxt = {w_sum, r_a[WIDTH-1:DIGIT]};
    assign w_b_nxt = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
  end else begin : g_single
    assign w_a_nxt = w_sum;
    assign w_b_nxt = '0;
  end

  assign w_run    = (r_state == RUN);
  assign w_last   = w_run && (r_cnt == '0);
  assign w_accept = start &&
                    ((r_state == IDLE) || (r_state == DONE));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_cnt   <= CW'(N - 1);
    end else if (w_run) begin
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_carry <= w_c[DIGIT];
      r_cnt   <= r_cnt - 1'b1;
      if (w_last) begin
        r_s    <= w_a_nxt;
        r_cout <= w_c[DIGIT];
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_last) r_ovf <= w_c[DIGIT] ^ w_c[DIGIT-1];
  end

  assign ovf = r_ovf;
`endif

  assign busy = w_run;
  assign done = (r_state == DONE);
  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for the serial adder,
// WIDTH=8 with DIGIT=1 and DIGIT=4 instances.
module tb_serial_adder;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       st8, ci8, st4, ci4;
  logic [7:0] a8, b8, a4, b4;
  logic       bz8, dn8, co8, bz4, dn4, co4;
  logic [7:0] s8, s4;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ov8, ov4;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st8),
    .a     (a8),
    .b     (b8),
    .cin   (ci8),
    .busy  (bz8),
    .done  (dn8),
    .s     (s8),
    .cout  (co8)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ov8)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (st4),
    .a     (a4),
    .b     (b4),
    .cin   (ci4),
    .busy  (bz4),
    .done  (dn4),
    .s     (s4),
    .cout  (co4)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ov4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic ovf_of(input logic [7:0] x,
                                  input logic [7:0] y,
                                  input logic [7:0] r);
    return (x[7] == y[7]) && (r[7] != x[7]);
  endfunction

  // Returns #1 after the accepting edge, with start dropped.
  task automatic start_op(input bit sel, input logic [7:0] x,
                          input logic [7:0] y, input logic c);
    @(negedge clk);
    if (sel) begin st4 = 1; a4 = x; b4 = y; ci4 = c; end
    else     begin st8 = 1; a8 = x; b8 = y; ci8 = c; end
    @(posedge clk);
    #1;
    st8 = 0;
    st4 = 0;
  endtask

  task automatic wait_done(input bit sel, input int budget,
                           output int lat);
    lat = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk);
      #1;
      if (sel ? dn4 : dn8) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_done(input int cyc, output int n);
    n = 0;
    for (int c = 0; c < cyc; c++) begin
      @(posedge clk);
      #1;
      if (dn8) n++;
    end
  endtask

  vec_t       tv[10];
  int         lat;
  int         npul;
  logic [7:0] prev_s;

  initial begin
    tv[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tv[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv[4] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
    tv[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tv[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    tv[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tv[8] = '{8'hFE, 8'h01, 1'b1, 8'h00, 1'b1};
    tv[9] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1};

    rst_n = 1; st8 = 0; st4 = 0;
    a8 = 0; b8 = 0; ci8 = 0;
    a4 = 0; b4 = 0; ci4 = 0;
    #1 rst_n = 0;
    #11;
    chk("rst_busy", {31'd0, bz8}, 0);
    chk("rst_done", {31'd0, dn8}, 0);
    chk("rst_s", {24'd0, s8}, 0);
    chk("rst_cout", {31'd0, co8}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("rst_ovf", {31'd0, ov8}, 0);
`endif
    @(negedge clk);
    rst_n = 1;

    prev_s = 8'h00;
    for (int i = 0; i < 10; i++) begin
      start_op(0, tv[i].a, tv[i].b, tv[i].cin);
      chk("run_busy", {31'd0, bz8}, 1);
      chk("run_hold_s", {24'd0, s8}, {24'd0, prev_s});
      wait_done(0, 20, lat);
      chk("latency", lat, 8);
      chk("busy_at_done", {31'd0, bz8}, 0);
      chk("sum", {24'd0, s8}, {24'd0, tv[i].s});
      chk("cout", {31'd0, co8}, {31'd0, tv[i].cout});
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", {31'd0, ov8},
          {31'd0, ovf_of(tv[i].a, tv[i].b, tv[i].s)});
`endif
      @(posedge clk);
      #1;
      chk("done_pulse_end", {31'd0, dn8}, 0);
      chk("sum_held", {24'd0, s8}, {24'd0, tv[i].s});
      prev_s = tv[i].s;
    end

    // start during RUN must be ignored
    start_op(0, 8'h0F, 8'h01, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    st8 = 1; a8 = 8'h01; b8 = 8'h01;
    @(posedge clk);
    #1;
    st8 = 0;
    wait_done(0, 20, lat);
    chk("busy_start_lat", lat, 6);
    chk("busy_start_sum", {24'd0, s8}, 32'h10);
    count_done(12, npul);
    chk("busy_start_pulses", npul, 0);

    // back-to-back with start held through DONE
    @(negedge clk);
    st8 = 1; a8 = 8'h0F; b8 = 8'h01; ci8 = 0;
    @(posedge clk);
    #1;
    a8 = 8'h22; b8 = 8'h11;
    wait_done(0, 20, lat);
    chk("b2b_lat1", lat, 8);
    chk("b2b_sum1", {24'd0, s8}, 32'h10);
    @(posedge clk);
    #1;
    st8 = 0;
    chk("b2b_busy", {31'd0, bz8}, 1);
    chk("b2b_hold", {24'd0, s8}, 32'h10);
    wait_done(0, 20, lat);
    chk("b2b_gap", lat + 1, 9);
    chk("b2b_sum2", {24'd0, s8}, 32'h33);
    chk("b2b_cout2", {31'd0, co8}, 0);

    // reset in the fourth RUN cycle
    start_op(0, 8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("abort_busy", {31'd0, bz8}, 0);
    chk("abort_done", {31'd0, dn8}, 0);
    chk("abort_s", {24'd0, s8}, 0);
    chk("abort_cout", {31'd0, co8}, 0);
    @(negedge clk);
    rst_n = 1;
    count_done(15, npul);
    chk("abort_pulses", npul, 0);

    // DIGIT=4 instance
    start_op(1, 8'h7F, 8'h01, 1'b0);
    wait_done(1, 10, lat);
    chk("d4_lat", lat, 2);
    chk("d4_sum_a", {24'd0, s4}, 32'h80);
    chk("d4_cout_a", {31'd0, co4}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("d4_ovf_a", {31'd0, ov4}, 1);
`endif
    start_op(1, 8'h80, 8'h80, 1'b0);
    wait_done(1, 10, lat);
    chk("d4_lat_b", lat, 2);
    chk("d4_sum_b", {24'd0, s4}, 32'h00);
    chk("d4_cout_b", {31'd0, co4}, 1);
`ifdef SERIAL_ADDER_OVF_EN
    chk("d4_ovf_b", {31'd0, ov4}, 1);
`endif
    start_op(1, 8'h3C, 8'h0F, 1'b1);
    wait_done(1, 10, lat);
    chk("d4_sum_c", {24'd0, s4}, 32'h4C);
    chk("d4_cout_c", {31'd0, co4}, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("d4_ovf_c", {31'd0, ov4}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, multi-cycle successor to the team's combinational half/full adder blocks.
- Adds two WIDTH-bit operands plus carry-in, processing DIGIT bits per clock through a chain of full-adder cells; carry is held in a flop between digits.
- Start/busy/done handshake lets it sit beside small datapath controllers where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be at least 2.
- DIGIT, 1, bits added per clock; must divide WIDTH evenly; N = WIDTH/DIGIT is the number of digit cycles.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; the result is valid from this cycle onward.
- s  output  WIDTH  registered sum; holds the last result.
- cout  output  1  registered carry-out; holds the last result.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, s=0, cout=0.
  - Internal shift registers, carry flop and digit counter all cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: latch a, b, cin into the operand shift registers and carry flop; load counter with N-1; go to RUN.
  - start=0: remain in IDLE.
- RUN (busy=1), every edge:
  - Add the low DIGIT bits of A and B with the carry flop.
  - Shift the DIGIT sum bits into the MSB end of the result shift register.
  - Shift the operands right by DIGIT.
  - Update the carry flop; decrement the counter.
  - When the counter is 0 at an edge: copy the result shift register into s and the final carry into cout, then go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - start=1: accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - start=0: go to IDLE.
- Latency: done is high in the cycle after the Nth edge following the start-accepting edge (WIDTH=8, DIGIT=1 gives N=8). Back-to-back throughput is one result per N+1 cycles.
- start during RUN is ignored; the operand inputs are don't-care after acceptance.
- s and cout change only on the RUN→DONE edge and are stable at all other times, including during the following RUN.
- Arithmetic: {cout,s} = a + b + cin, unsigned, modulo 2^(WIDTH+1). No truncation beyond that.
- Reset asserted mid-operation: abort immediately; no done pulse; s and cout return to 0.
- No X propagation from the operand inputs when start=0.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0.
  - ovf = carry into the MSB XOR carry out of the MSB, i.e. two's-complement signed overflow.
  - Registered alongside s and cout on the RUN→DONE edge, and held with them.
- Undefined: the ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Counter-width function clog2(N), with a minimum of 1 bit.
- One natural sub-module, full_adder_cell:
  - Combinational 1-bit sum/carry.
  - DIGIT instances chained via generate inside serial_adder.

Test Plan:
- Carry propagation (WIDTH=8, DIGIT=1): a=0x0F, b=0x01, cin=0, start pulse → busy high 8 cycles; done pulses on the 8th edge after start; s=0x10, cout=0.
- Wrap-around: a=0xFF, b=0x01, cin=0 → s=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → s=0xFF, cout=1.
- Start while busy: a start pulse in RUN with new operands a=0x01, b=0x01 is ignored; the original result is delivered and exactly one done pulse is seen.
- Back-to-back: start held high through DONE → second operation begins without passing through IDLE; two done pulses 9 cycles apart; s holds the first result until the second done.
- Reset mid-operation: rst_n low in the 4th RUN cycle → busy=0, done=0, s=0, cout=0 immediately; no done pulse after release.
- DIGIT=4, WIDTH=8: a=0x7F, b=0x01 → done on the 2nd edge; s=0x80, cout=0; with SERIAL_ADDER_OVF_EN defined, ovf=1; 0x80+0x80 gives s=0x00, cout=1, ovf=1.
